// File: rtl/display_scan_ctrl.sv
// Scan controller for a 4-digit multiplexed 7-segment display.
// It holds a per-slot blanking interval, and staged values commit only at frame boundaries.
//
// state   | meaning
// --------+-------------------------------------------------------
// S_BLANK | all anodes off, cnt < BLANK_CYCLES (anti-ghosting gap)
// S_ON    | anode of current slot enabled, cnt >= BLANK_CYCLES
module display_scan_ctrl #(
    parameter int TICK_DIV     = 25000,
    parameter int BLANK_CYCLES = 250,
    parameter int SUPPRESS_LZ  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic       sign_in,
    input  logic [3:0] d2_in,
    input  logic [3:0] d1_in,
    input  logic [3:0] d0_in,
    output logic       ready,
    output logic       frame_done,
    output logic [1:0] digit_sel,
    output logic [3:0] digit_val,
    output logic [3:0] anode_active
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [CW-1:0] CNT_ON   = CW'(BLANK_CYCLES);

    localparam logic [0:0] S_BLANK = 1'b0;
    localparam logic [0:0] S_ON    = 1'b1;
    localparam logic [0:0] S_RESET = (BLANK_CYCLES == 0) ? S_ON : S_BLANK;

    logic [1:0]    slot_q, slot_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [0:0]    state_q, state_d;
    logic [12:0]   pend_q, pend_d;        // {sign, d2, d1, d0}
    logic          pend_valid_q, pend_valid_d;
    logic [12:0]   act_q, act_d;
    logic          wrap, boundary, accept;

    always_comb begin
        wrap         = (cnt_q == CNT_LAST);
        boundary     = wrap && (slot_q == 2'd3);
        accept       = load && !pend_valid_q;
        cnt_d        = wrap ? '0 : cnt_q + 1'b1;
        slot_d       = wrap ? slot_q + 2'd1 : slot_q;
        state_d      = (cnt_d < CNT_ON) ? S_BLANK : S_ON;
        pend_d       = accept ? {sign_in, d2_in, d1_in, d0_in} : pend_q;
        // A load captured on the boundary edge must survive that edge uncommitted.
        pend_valid_d = accept | (pend_valid_q & ~boundary);
        act_d        = (boundary && pend_valid_q) ? pend_q : act_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_q       <= 2'd0;
            cnt_q        <= '0;
            state_q      <= S_RESET;
            pend_q       <= '0;
            pend_valid_q <= 1'b0;
            act_q        <= '0;
        end else begin
            slot_q       <= slot_d;
            cnt_q        <= cnt_d;
            state_q      <= state_d;
            pend_q       <= pend_d;
            pend_valid_q <= pend_valid_d;
            act_q        <= act_d;
        end
    end

    logic       act_sign;
    logic [3:0] act_d2, act_d1, act_d0;

    always_comb begin
        {act_sign, act_d2, act_d1, act_d0} = act_q;
        ready        = ~pend_valid_q;
        frame_done   = boundary;
        digit_sel    = slot_q;
        anode_active = (state_q == S_ON) ? ~(4'b0001 << slot_q) : 4'b1111;
        case (slot_q)
            2'd0: digit_val = act_d0;
            2'd1: digit_val = (SUPPRESS_LZ != 0 && act_d2 == 4'd0 && act_d1 == 4'd0) ? 4'hF : act_d1;
            2'd2: digit_val = (SUPPRESS_LZ != 0 && act_d2 == 4'd0) ? 4'hF : act_d2;
            default: digit_val = (act_sign && {act_d2, act_d1, act_d0} != 12'd0) ? 4'hA : 4'hF;
        endcase
    end

endmodule
